// File: rtl/multicycle_control_unit_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit_if : fetch/memory/print handshakes and control strobes
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_unit_if #(
  parameter int ALU_W = 3
);
  logic             instr_valid;
  logic [31:0]      instr;
  logic             instr_ready;
  logic             alu_zero;
  logic             mem_ready;
  logic             print_ready;
  logic             regwrite;
  logic             memread;
  logic             memwrite;
  logic             memtoreg;
  logic             alusrc;
  logic [ALU_W-1:0] alucont;
  logic             brancheq;
  logic             branchne;
  logic             jmp;
  logic             jalr;
  logic             print_valid;
  logic             pc_write;
  logic             branch_taken;
  logic             illegal;
  logic             mem_err;
  logic             busy;

  modport slave (
    input  instr_valid, instr, alu_zero, mem_ready, print_ready,
    output instr_ready, regwrite, memread, memwrite, memtoreg, alusrc, alucont,
           brancheq, branchne, jmp, jalr, print_valid, pc_write, branch_taken,
           illegal, mem_err, busy
  );

  modport master (
    output instr_valid, instr, alu_zero, mem_ready, print_ready,
    input  instr_ready, regwrite, memread, memwrite, memtoreg, alusrc, alucont,
           brancheq, branchne, jmp, jalr, print_valid, pc_write, branch_taken,
           illegal, mem_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit : Xenyx-4 multi-cycle control FSM (DECODE/EXEC/MEM/WB/PRINT)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit #(
  parameter int ALU_W       = 3,
  parameter bit ENABLE_BNE  = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  multicycle_control_unit_if.slave  bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_PRINT = 7'h7F;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PRINT  = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_ALU   = 4'd0,
    K_LOAD  = 4'd1,
    K_STORE = 4'd2,
    K_BEQ   = 4'd3,
    K_BNE   = 4'd4,
    K_JAL   = 4'd5,
    K_JALR  = 4'd6,
    K_PRINT = 4'd7,
    K_ILL   = 4'd8
  } kind_t;

  state_t           r_state, w_next;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic [6:0]       r_funct7;
  kind_t            r_kind, w_kind;
  logic [2:0]       r_alu, w_alu, w_f3_alu;
  logic             r_alusrc, w_alusrc, w_f3_ok;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;

  logic       w_instr_ready, w_regwrite, w_memread, w_memwrite, w_memtoreg;
  logic       w_alusrc_o, w_brancheq, w_branchne, w_jmp, w_jalr, w_print_valid;
  logic       w_pc_write, w_branch_taken, w_illegal, w_mem_err;
  logic [2:0] w_alucont;

  // Register-address and immediate fields belong to the datapath.
  logic w_unused;
  assign w_unused = ^{bus.instr[24:15], bus.instr[11:7]};

  assign w_timeout = (MEM_TIMEOUT != 0) && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_f3_ok  = 1'b1;
    w_f3_alu = ALU_ADD;
    case (r_funct3)
      3'b000:  w_f3_alu = ALU_ADD;
      3'b111:  w_f3_alu = ALU_AND;
      3'b110:  w_f3_alu = ALU_OR;
      3'b100:  w_f3_alu = ALU_XOR;
      3'b001:  w_f3_alu = ALU_SLL;
      3'b101:  w_f3_alu = ALU_SRL;
      3'b010:  w_f3_alu = ALU_SLT;
      default: w_f3_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_kind   = K_ILL;
    w_alu    = ALU_ADD;
    w_alusrc = 1'b0;
    case (r_opcode)
      OP_R: begin
        if (r_funct3 == 3'b000) begin
          if (r_funct7 == 7'b0000000) begin
            w_kind = K_ALU;
            w_alu  = ALU_ADD;
          end else if (r_funct7 == 7'b0100000) begin
            w_kind = K_ALU;
            w_alu  = ALU_SUB;
          end
        end else if (w_f3_ok && r_funct7 == 7'b0000000) begin
          w_kind = K_ALU;
          w_alu  = w_f3_alu;
        end
      end
      OP_I: begin
        w_alusrc = 1'b1;
        // funct7 only qualifies the shift encodings of the immediate form
        if (w_f3_ok && ((r_funct3 != 3'b001 && r_funct3 != 3'b101) ||
                        r_funct7 == 7'b0000000)) begin
          w_kind = K_ALU;
          w_alu  = w_f3_alu;
        end
      end
      OP_LOAD: begin
        w_kind   = K_LOAD;
        w_alusrc = 1'b1;
      end
      OP_STORE: begin
        w_kind   = K_STORE;
        w_alusrc = 1'b1;
      end
      OP_BR: begin
        w_alu = ALU_SUB;
        if (r_funct3 == 3'b000)
          w_kind = K_BEQ;
        else if (r_funct3 == 3'b001 && ENABLE_BNE)
          w_kind = K_BNE;
      end
      OP_JAL:   w_kind = K_JAL;
      OP_JALR: begin
        w_kind   = K_JALR;
        w_alusrc = 1'b1;
      end
      OP_PRINT: w_kind = K_PRINT;
      default:  w_kind = K_ILL;
    endcase
    if (w_kind == K_ILL) begin
      w_alu    = ALU_ADD;
      w_alusrc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= 7'd0;
      r_funct3 <= 3'd0;
      r_funct7 <= 7'd0;
      r_kind   <= K_ALU;
      r_alu    <= ALU_ADD;
      r_alusrc <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (r_state == S_IDLE && bus.instr_valid) begin
        r_opcode <= bus.instr[6:0];
        r_funct3 <= bus.instr[14:12];
        r_funct7 <= bus.instr[31:25];
      end
      if (r_state == S_DECODE) begin
        r_kind   <= w_kind;
        r_alu    <= w_alu;
        r_alusrc <= w_alusrc;
      end
      if (r_state == S_MEM && !bus.mem_ready)
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_instr_ready  = 1'b0;
    w_regwrite     = 1'b0;
    w_memread      = 1'b0;
    w_memwrite     = 1'b0;
    w_memtoreg     = 1'b0;
    w_alusrc_o     = 1'b0;
    w_alucont      = ALU_ADD;
    w_brancheq     = 1'b0;
    w_branchne     = 1'b0;
    w_jmp          = 1'b0;
    w_jalr         = 1'b0;
    w_print_valid  = 1'b0;
    w_pc_write     = 1'b0;
    w_branch_taken = 1'b0;
    w_illegal      = 1'b0;
    w_mem_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_instr_ready = 1'b1;
        if (bus.instr_valid)
          w_next = S_DECODE;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_alucont  = r_alu;
        w_alusrc_o = r_alusrc;
        case (r_kind)
          K_LOAD, K_STORE: w_next = S_MEM;
          K_BEQ: begin
            w_brancheq     = 1'b1;
            w_pc_write     = 1'b1;
            w_branch_taken = bus.alu_zero;
            w_next         = S_IDLE;
          end
          K_BNE: begin
            w_branchne     = 1'b1;
            w_pc_write     = 1'b1;
            w_branch_taken = !bus.alu_zero;
            w_next         = S_IDLE;
          end
          K_PRINT: w_next = S_PRINT;
          K_ILL: begin
            w_illegal = 1'b1;
            w_next    = S_IDLE;
          end
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_alucont  = r_alu;
        w_alusrc_o = r_alusrc;
        w_memread  = (r_kind == K_LOAD);
        w_memwrite = (r_kind == K_STORE);
        if (bus.mem_ready) begin
          if (r_kind == K_LOAD) begin
            w_next = S_WB;
          end else begin
            w_pc_write = 1'b1;
            w_next     = S_IDLE;
          end
        end else if (w_timeout) begin
          w_mem_err = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WB: begin
        w_regwrite = 1'b1;
        w_pc_write = 1'b1;
        w_memtoreg = (r_kind == K_LOAD);
        w_jmp      = (r_kind == K_JAL) || (r_kind == K_JALR);
        w_jalr     = (r_kind == K_JALR);
        w_next     = S_IDLE;
      end
      S_PRINT: begin
        w_print_valid = 1'b1;
        if (bus.print_ready) begin
          w_pc_write = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.instr_ready  = w_instr_ready;
  assign bus.regwrite     = w_regwrite;
  assign bus.memread      = w_memread;
  assign bus.memwrite     = w_memwrite;
  assign bus.memtoreg     = w_memtoreg;
  assign bus.alusrc       = w_alusrc_o;
  assign bus.alucont      = ALU_W'(w_alucont);
  assign bus.brancheq     = w_brancheq;
  assign bus.branchne     = w_branchne;
  assign bus.jmp          = w_jmp;
  assign bus.jalr         = w_jalr;
  assign bus.print_valid  = w_print_valid;
  assign bus.pc_write     = w_pc_write;
  assign bus.branch_taken = w_branch_taken;
  assign bus.illegal      = w_illegal;
  assign bus.mem_err      = w_mem_err;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_unit : scoreboard bench with a retire-level reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_unit;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_W(3)) bus ();

  multicycle_control_unit #(
    .ALU_W(3), .ENABLE_BNE(1'b1), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int lat; bit pcw; bit bt; bit ill; bit merr;
    int alu; bit asrc; bit beq; bit bne;
    int rw; bit m2r; bit jmp; bit jalr; int memc; int prc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cur_mw = 0;
  int   cur_pw = 0;
  bit   cur_zero = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Retire-level expectation of one instruction, given the environment it sees.
  function automatic exp_t model(input logic [31:0] ins, input bit z, input int mw, input int pw);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int code;
    e = '{default: 0};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e.lat = 2; e.ill = 1'b1;
    case (f3)
      3'd0: code = 0;  3'd7: code = 2;  3'd6: code = 3;  3'd4: code = 4;
      3'd1: code = 5;  3'd5: code = 6;  3'd2: code = 7;  default: code = -1;
    endcase
    if (op == 7'h33 || op == 7'h13) begin
      if (op == 7'h33) begin
        if (f3 == 3'd0) code = (f7 == 7'h00) ? 0 : (f7 == 7'h20) ? 1 : -1;
        else if (f7 != 7'h00) code = -1;
      end else if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) begin
        code = -1;
      end
      if (code >= 0) begin
        e.ill = 0; e.pcw = 1; e.lat = 3; e.rw = 1; e.alu = code; e.asrc = (op == 7'h13);
      end
    end else if (op == 7'h03 || op == 7'h23) begin
      e.ill = 0; e.asrc = 1;
      if (mw >= TO) begin
        e.merr = 1; e.lat = 2 + TO; e.memc = TO;
      end else begin
        e.pcw = 1; e.memc = mw + 1;
        if (op == 7'h03) begin e.lat = 4 + mw; e.rw = 1; e.m2r = 1; end
        else e.lat = 3 + mw;
      end
    end else if (op == 7'h63) begin
      if (f3 == 3'd0 || f3 == 3'd1) begin
        e.ill = 0; e.pcw = 1; e.alu = 1;
        e.beq = (f3 == 3'd0); e.bne = (f3 == 3'd1);
        e.bt = e.beq ? z : !z;
      end
    end else if (op == 7'h6F || op == 7'h67) begin
      e.ill = 0; e.pcw = 1; e.lat = 3; e.rw = 1; e.jmp = 1;
      e.jalr = (op == 7'h67); e.asrc = (op == 7'h67);
    end else if (op == 7'h7F) begin
      e.ill = 0; e.pcw = 1; e.lat = 3 + pw; e.prc = pw + 1;
    end
    return e;
  endfunction

  // Environment responder: drives handshakes just after each rising edge.
  int mcnt = 0;
  int pcnt = 0;
  initial begin
    bus.mem_ready = 1'b0; bus.print_ready = 1'b0; bus.alu_zero = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.memread || bus.memwrite) begin
        bus.mem_ready = (mcnt >= cur_mw); mcnt++;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1)); mcnt = 0;
      end
      if (bus.print_valid) begin
        bus.print_ready = (pcnt >= cur_pw); pcnt++;
      end else begin
        bus.print_ready = 1'($urandom_range(0, 1)); pcnt = 0;
      end
      bus.alu_zero = (bus.brancheq || bus.branchne) ? cur_zero : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: accumulates strobes per instruction and scores on retirement.
  initial begin
    int acc, memc, prc, rw, e_alu;
    bit m2r, jmp, jalr, e_asrc, e_beq, e_bne;
    exp_t e;
    acc = -100; memc = 0; prc = 0; rw = 0; e_alu = 0;
    m2r = 0; jmp = 0; jalr = 0; e_asrc = 0; e_beq = 0; e_bne = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc = -100;
      end else if (bus.instr_ready) begin
        chk("idle_quiet", {bus.busy, bus.regwrite, bus.memread, bus.memwrite, bus.pc_write,
                           bus.illegal, bus.mem_err, bus.print_valid, bus.brancheq, bus.branchne}, 0);
        if (bus.instr_valid) begin
          acc = cyc; memc = 0; prc = 0; rw = 0; m2r = 0; jmp = 0; jalr = 0;
          e_alu = 0; e_asrc = 0; e_beq = 0; e_bne = 0;
        end
      end else begin
        if (cyc == acc + 2) begin
          e_alu = int'(bus.alucont); e_asrc = bus.alusrc;
          e_beq = bus.brancheq; e_bne = bus.branchne;
        end
        memc += int'(bus.memread | bus.memwrite);
        prc  += int'(bus.print_valid);
        rw   += int'(bus.regwrite);
        m2r  |= bus.memtoreg; jmp |= bus.jmp; jalr |= bus.jalr;
        if (bus.pc_write || bus.illegal || bus.mem_err) begin
          if (q.size() == 0) begin
            chk("unexpected_retire", 1, 0);
          end else begin
            e = q.pop_front();
            chk("latency", cyc - acc, e.lat);
            chk("pc_write", bus.pc_write, e.pcw);
            chk("branch_taken", bus.branch_taken, e.bt);
            chk("illegal", bus.illegal, e.ill);
            chk("mem_err", bus.mem_err, e.merr);
            chk("exec_alucont", e_alu, e.alu);
            chk("exec_alusrc", e_asrc, e.asrc);
            chk("exec_brancheq", e_beq, e.beq);
            chk("exec_branchne", e_bne, e.bne);
            chk("regwrite_cycles", rw, e.rw);
            chk("memtoreg", m2r, e.m2r);
            chk("jmp", jmp, e.jmp);
            chk("jalr", jalr, e.jalr);
            chk("mem_cycles", memc, e.memc);
            chk("print_cycles", prc, e.prc);
          end
          acc = -100;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input logic [31:0] ins, input bit z, input int mw, input int pw);
    int n;
    n = 0;
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    forever begin
      @(negedge clk);
      if (bus.instr_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_wait", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "fetch handshake stalled");
      end
    end
    cur_zero = z; cur_mw = mw; cur_pw = pw;
    q.push_back(model(ins, z, mw, pw));
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr = $urandom;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [6:0] ops [8];
    int waits [8];
    logic [31:0] ins;
    logic [6:0] op, f7;
    int n;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F};
    waits = '{0, 0, 1, 2, 3, 14, 15, 40};
    bus.instr_valid = 1'b0;
    bus.instr = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_instr_ready", bus.instr_ready, 1);
    chk("reset_outputs", {bus.busy, bus.regwrite, bus.memread, bus.memwrite, bus.memtoreg,
                          bus.alusrc, bus.alucont, bus.brancheq, bus.branchne, bus.jmp, bus.jalr,
                          bus.print_valid, bus.pc_write, bus.branch_taken, bus.illegal,
                          bus.mem_err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h40208033, 1'b0, 0, 0);
    issue(32'h00002083, 1'b0, 3, 0);
    issue(32'h00202023, 1'b0, 99, 0);
    issue(32'h00209063, 1'b0, 0, 0);
    issue(32'h00209063, 1'b1, 0, 0);
    issue(32'h00208063, 1'b1, 0, 0);
    issue(32'h0000007F, 1'b0, 0, 2);
    issue(32'h0000000B, 1'b0, 0, 0);
    issue(32'h00002083, 1'b0, 0, 0);
    issue(32'h00002083, 1'b0, 14, 0);
    issue(32'h00202023, 1'b0, 0, 0);
    issue(32'h0020A033, 1'b0, 0, 0);
    issue(32'h4020D013, 1'b0, 0, 0);

    for (int i = 0; i < 250; i++) begin
      n = $urandom_range(0, 9);
      op = (n < 8) ? ops[n] : 7'($urandom);
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      ins = $urandom;
      ins[6:0] = op;
      ins[31:25] = f7;
      issue(ins, 1'($urandom_range(0, 1)), waits[$urandom_range(0, 7)], $urandom_range(0, 3));
    end

    n = 0;
    while ((q.size() != 0 || !bus.instr_ready) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", q.size(), 0);

    // Asynchronous reset while a load is waiting in MEM.
    bus.instr_valid = 1'b1;
    bus.instr = 32'h00002083;
    @(negedge clk);
    cur_mw = 99;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_memread", bus.memread, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_memread", bus.memread, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_instr_ready", bus.instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_quiet", {bus.busy, bus.regwrite, bus.pc_write, bus.mem_err, bus.memread,
                               bus.memtoreg}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
